// File: rtl/size_field_patcher.sv
// size_field_patcher: buffers size-field back-patch requests and replays them as byte writes.
// Define SIZE_FIELD_PATCHER_LE_EN to emit fields little-endian instead of big-endian.
module size_field_patcher #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 24
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [31:0]       offset_addr,
    input  logic [31:0]       val,
    input  logic [31:0]       byte_size,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic [15:0]       patch_count,
    output logic              overflow,
    output logic              size_error
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic {IDLE, WRITE} state_t;

    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [31:0]       fifo_val  [DEPTH];
    logic [2:0]        fifo_size [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;
    state_t            state, state_nxt;
    logic [31:0]       cur_val, head_aligned, head_rest, cur_rest;
    logic [7:0]        head_byte, cur_byte;
    logic [2:0]        remaining, h_size;
    logic [ADDR_W-1:0] h_addr;
    logic [31:0]       h_val;
    logic              push_req, full, push, pop, last;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^offset_addr;
    assign h_addr   = fifo_addr[rd_ptr];
    assign h_val    = fifo_val[rd_ptr];
    assign h_size   = fifo_size[rd_ptr];
    assign push_req = (byte_size != 32'd0) && (byte_size <= 32'd4);
    assign full     = count == FULL_CNT;
    assign push     = push_req && !full;
    // the !mem_we term enforces the one idle cycle after each patch's last byte
    assign pop      = (state == IDLE) && (count != '0) && !mem_we;
    assign last     = (pop && h_size == 3'd1) || (state == WRITE && remaining == 3'd1);
    assign busy     = (count != '0) || (state == WRITE) || mem_we;

`ifdef SIZE_FIELD_PATCHER_LE_EN
    assign head_aligned = h_val;
    assign head_byte    = head_aligned[7:0];
    assign head_rest    = head_aligned >> 8;
    assign cur_byte     = cur_val[7:0];
    assign cur_rest     = cur_val >> 8;
`else
    // left-align the field so its most significant byte always sits in [31:24]
    assign head_aligned = h_val << {3'd4 - h_size, 3'b000};
    assign head_byte    = head_aligned[31:24];
    assign head_rest    = head_aligned << 8;
    assign cur_byte     = cur_val[31:24];
    assign cur_rest     = cur_val << 8;
`endif

    always_comb begin
        state_nxt = pop ? (h_size == 3'd1 ? IDLE : WRITE)
                        : ((state == WRITE && remaining == 3'd1) ? IDLE : state);
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr[wr_ptr] <= offset_addr[ADDR_W-1:0];
            fifo_val[wr_ptr]  <= val;
            fifo_size[wr_ptr] <= byte_size[2:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            cur_val     <= '0;
            remaining   <= '0;
            patch_count <= '0;
            overflow    <= 1'b0;
            size_error  <= 1'b0;
        end else begin
            state  <= state_nxt;
            wr_ptr <= push ? wr_ptr + PW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + PW'(1) : rd_ptr;
            count  <= count + (PW+1)'(push) - (PW+1)'(pop);
            mem_we <= pop || (state == WRITE);
            if (pop) begin
                mem_addr  <= h_addr;
                mem_wdata <= head_byte;
                cur_val   <= head_rest;
                remaining <= h_size - 3'd1;
            end else if (state == WRITE) begin
                mem_addr  <= mem_addr + ADDR_W'(1);
                mem_wdata <= cur_byte;
                cur_val   <= cur_rest;
                remaining <= remaining - 3'd1;
            end
            if (last)
                patch_count <= patch_count + 16'd1;
            if (push_req && full)
                overflow <= 1'b1;
            if (byte_size > 32'd4)
                size_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_size_field_patcher.sv
// tb_size_field_patcher: queue-based reference model plus directed back-patch scenarios.
module tb_size_field_patcher;
    localparam int DEPTH = 4;
`ifdef SIZE_FIELD_PATCHER_LE_EN
    localparam bit LE = 1'b1;
    localparam logic [31:0] T1 [2] = '{32'h00001034, 32'h00001112};
    localparam logic [31:0] T2 [10] = '{32'h000020BC, 32'h0000210A,
        32'h00000834, 32'h00000912, 32'h00000A00, 32'h00000B00,
        32'h00000078, 32'h00000156, 32'h00000200, 32'h00000300};
    localparam logic [31:0] T3_FIRST = 32'h00010004;
    localparam logic [31:0] T5 [2] = '{32'hFFFFFFBB, 32'h000000AA};
`else
    localparam bit LE = 1'b0;
    localparam logic [31:0] T1 [2] = '{32'h00001012, 32'h00001134};
    localparam logic [31:0] T2 [10] = '{32'h0000200A, 32'h000021BC,
        32'h00000800, 32'h00000900, 32'h00000A12, 32'h00000B34,
        32'h00000000, 32'h00000100, 32'h00000256, 32'h00000378};
    localparam logic [31:0] T3_FIRST = 32'h00010001;
    localparam logic [31:0] T5 [2] = '{32'hFFFFFFAA, 32'h000000BB};
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] offset_addr = '0, val = '0, byte_size = '0;
    logic        mem_we, busy, overflow, size_error;
    logic [23:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [15:0] patch_count;

    int n_vec = 0;
    int n_err = 0;

    size_field_patcher #(.DEPTH(DEPTH), .ADDR_W(24)) dut (
        .clock(clk), .reset_n(rst_n), .offset_addr(offset_addr), .val(val),
        .byte_size(byte_size), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .patch_count(patch_count),
        .overflow(overflow), .size_error(size_error));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] off;
        logic [31:0] v;
        logic [2:0]  sz;
    } req_t;

    req_t        q[$];
    logic [31:0] bq[$];
    logic [31:0] wlog[$];
    req_t        r;
    int          pre, sh;
    logic        m_we, m_ovf, m_serr;
    logic [23:0] m_addr;
    logic [7:0]  m_data;
    logic [15:0] m_pc;

    // reference: each request expands into a list of {addr, byte} writes
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete(); bq.delete();
            m_we = 0; m_addr = 0; m_data = 0; m_pc = 0; m_ovf = 0; m_serr = 0;
        end else begin
            pre = q.size();
            if (bq.size() > 0 || (!m_we && q.size() > 0)) begin
                if (bq.size() == 0) begin
                    r = q.pop_front();
                    for (int i = 0; i < int'(r.sz); i++) begin
                        sh = LE ? 8 * i : 8 * (int'(r.sz) - 1 - i);
                        bq.push_back({24'(r.off + 24'(i)), 8'(r.v >> sh)});
                    end
                end
                {m_addr, m_data} = bq.pop_front();
                m_we = 1;
                if (bq.size() == 0) m_pc = m_pc + 16'd1;
            end else
                m_we = 0;
            if (byte_size > 4) m_serr = 1;
            else if (byte_size != 0) begin
                if (pre < DEPTH) q.push_back({offset_addr[23:0], val, byte_size[2:0]});
                else m_ovf = 1;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] log_at(input int i);
        return (wlog.size() > i) ? wlog[i] : 32'hDEAD_DEAD;
    endfunction

    initial forever begin
        @(posedge clk);
        #2;
        check("mem_we", 32'(mem_we), 32'(m_we));
        check("mem_addr", 32'(mem_addr), 32'(m_addr));
        check("mem_wdata", 32'(mem_wdata), 32'(m_data));
        check("busy", 32'(busy), 32'(q.size() > 0 || bq.size() > 0 || m_we));
        check("patch_count", 32'(patch_count), 32'(m_pc));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("size_error", 32'(size_error), 32'(m_serr));
        if (mem_we) wlog.push_back({mem_addr, mem_wdata});
    end

    task automatic drive(input logic [31:0] o, input logic [31:0] v, input logic [31:0] s);
        offset_addr = o; val = v; byte_size = s;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        byte_size = 0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_we", 32'(mem_we), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_data", 32'(mem_wdata), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pc", 32'(patch_count), 0);
        check("rst_flags", {30'd0, overflow, size_error}, 0);
        rst_n = 1;
        idle(2);

        wlog.delete();
        drive(32'h10, 32'h1234, 2);
        idle(5);
        check("t1_len", wlog.size(), 2);
        for (int i = 0; i < 2; i++) check("t1_byte", log_at(i), T1[i]);
        check("t1_pc", 32'(patch_count), 1);
        check("t1_model_pc", 32'(m_pc), 1);

        wlog.delete();
        drive(32'h20, 32'h0ABC, 2);
        drive(32'h08, 32'h00001234, 4);
        drive(32'h00, 32'h00005678, 4);
        idle(15);
        check("t2_len", wlog.size(), 10);
        for (int i = 0; i < 10; i++) check("t2_byte", log_at(i), T2[i]);
        check("t2_pc", 32'(patch_count), 4);
        check("t2_ovf", 32'(overflow), 0);

        wlog.delete();
        for (int i = 0; i < 6; i++) drive(32'h100 + 32'(4 * i), 32'h01020304 + 32'(i), 4);
        idle(40);
        check("t3_len", wlog.size(), 20);
        check("t3_first", log_at(0), T3_FIRST);
        check("t3_ovf", 32'(overflow), 1);
        check("t3_pc", 32'(patch_count), 9);

        wlog.delete();
        drive(32'h40, 32'h11223344, 5);
        drive(32'h50, 32'h77, 1);
        idle(5);
        check("t4_serr", 32'(size_error), 1);
        check("t4_len", wlog.size(), 1);
        check("t4_byte", log_at(0), 32'h00005077);
        check("t4_pc", 32'(patch_count), 10);

        wlog.delete();
        drive(32'h55FF_FFFF, 32'hCC00_AABB, 2);
        idle(5);
        check("t5_len", wlog.size(), 2);
        for (int i = 0; i < 2; i++) check("t5_byte", log_at(i), T5[i]);
        check("t5_pc", 32'(patch_count), 11);

        drive(32'h200, 32'hDEADBEEF, 4);
        byte_size = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 0;
        #1;
        check("t6_we_drop", 32'(mem_we), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_pc", 32'(patch_count), 0);
        check("t6_flags", {30'd0, overflow, size_error}, 0);
        @(negedge clk);
        rst_n = 1;
        idle(1);
        wlog.delete();
        drive(32'h300, 32'h5A, 1);
        idle(4);
        check("t6_len", wlog.size(), 1);
        check("t6_byte", log_at(0), 32'h0003005A);
        check("t6_pc_after", 32'(patch_count), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
